// File: rtl/mt2015_q4_pkg.sv
// Shared constants for the mt2015_q4 glue network.
package mt2015_q4_pkg;

  // Expected z indexed by {x, y}: 00->1, 01->0, 10->1, 11->1.
  localparam logic [3:0] MT2015_Q4_TRUTH = 4'b1101;

endpackage

// File: rtl/mt2015_q4_lane.sv
// One bit-lane: two A cells and two B cells wired into the OR/AND/XOR network.
module mt2015_q4_lane
  import mt2015_q4_pkg::*;
(
  input  logic x_i,
  input  logic y_i,
  output logic z_o
);

  function automatic logic cell_a(input logic x, input logic y);
    return (x ^ y) & x;
  endfunction

  function automatic logic cell_b(input logic x, input logic y);
    return ~(x ^ y);
  endfunction

  logic a1, b1, a2, b2;
  logic o, n;

  always_comb begin
    a1  = cell_a(x_i, y_i);
    b1  = cell_b(x_i, y_i);
    a2  = cell_a(x_i, y_i);
    b2  = cell_b(x_i, y_i);
    o   = a1 | b1;
    n   = a2 & b2;
    z_o = o ^ n;
  end

endmodule

// File: rtl/mt2015_q4.sv
// WIDTH independent network lanes with a combinational result and a registered copy.
module mt2015_q4
  import mt2015_q4_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_q
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    mt2015_q4_lane u_lane (
      .x_i (x[g]),
      .y_i (y[g]),
      .z_o (z[g])
    );

    a_lane_truth : assert property (@(posedge clk)
      !$isunknown({x[g], y[g]}) |-> (z[g] == MT2015_Q4_TRUTH[{x[g], y[g]}]))
      else $error("lane %0d disagrees with truth table", g);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z_q <= '0;
    else        z_q <= z;
  end

  a_net_function : assert property (@(posedge clk)
    !$isunknown({x, y}) |-> (z == (x | ~y)))
    else $error("z differs from x | ~y");

endmodule

// File: tb/tb_mt2015_q4.sv
// Directed bench for mt2015_q4 at WIDTH=1 and WIDTH=4.
module tb_mt2015_q4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       x1 = 1'b0, y1 = 1'b0;
  logic       z1, zq1;
  logic [3:0] x4 = '0, y4 = '0;
  logic [3:0] z4, zq4;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  mt2015_q4 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .z(z1), .z_q(zq1)
  );

  mt2015_q4 #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .z(z4), .z_q(zq4)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if (zq1 !== 1'b0) begin bad++; $display("FAIL reset_zq1 got=%b want=0", zq1); end
    total++;
    if (zq4 !== 4'b0000) begin bad++; $display("FAIL reset_zq4 got=%b want=0000", zq4); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [1:0] xy [4];
    logic       want [4];
    xy[0] = 2'b00; want[0] = 1'b1;
    xy[1] = 2'b01; want[1] = 1'b0;
    xy[2] = 2'b10; want[2] = 1'b1;
    xy[3] = 2'b11; want[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x1 = xy[i][1];
      y1 = xy[i][0];
      #0;
      #1;
      total++;
      if (z1 !== want[i]) begin
        bad++; $display("FAIL sweep_z xy=%b got=%b want=%b", xy[i], z1, want[i]);
      end
      @(posedge clk); #1;
      total++;
      if (zq1 !== want[i]) begin
        bad++; $display("FAIL sweep_zq xy=%b got=%b want=%b", xy[i], zq1, want[i]);
      end
    end
  endtask

  task automatic test_random_edges();
    logic want;
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) @(posedge clk); else @(negedge clk);
      x1 = 1'($urandom_range(0, 1));
      y1 = 1'($urandom_range(0, 1));
      #1;
      want = x1 | ~y1;
      total++;
      if (z1 !== want) begin
        bad++; $display("FAIL random_z i=%0d x=%b y=%b got=%b want=%b", i, x1, y1, z1, want);
      end
    end
  endtask

  task automatic test_reset_hold();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x1 = i[1];
      y1 = i[0];
      @(posedge clk); #1;
      total++;
      if (zq1 !== 1'b0) begin bad++; $display("FAIL hold_zq i=%0d got=%b want=0", i, zq1); end
      total++;
      if (z1 !== (x1 | ~y1)) begin
        bad++; $display("FAIL hold_z i=%0d got=%b want=%b", i, z1, x1 | ~y1);
      end
    end
    @(negedge clk);
    x1 = 1'b0; y1 = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (zq1 !== 1'b0) begin bad++; $display("FAIL release_zq01 got=%b want=0", zq1); end
    @(negedge clk);
    x1 = 1'b1; y1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (zq1 !== 1'b1) begin bad++; $display("FAIL release_zq11 got=%b want=1", zq1); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    x1 = 1'b1; y1 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (zq1 !== 1'b1) begin bad++; $display("FAIL async_pre got=%b want=1", zq1); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (zq1 !== 1'b0) begin bad++; $display("FAIL async_clear got=%b want=0", zq1); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wide();
    @(negedge clk);
    x4 = 4'b0101; y4 = 4'b0011;
    #1;
    total++;
    if (z4 !== 4'b1101) begin bad++; $display("FAIL wide_z got=%b want=1101", z4); end
    @(posedge clk); #1;
    total++;
    if (zq4 !== 4'b1101) begin bad++; $display("FAIL wide_zq got=%b want=1101", zq4); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    x1 = 1'b0; y1 = 1'b0;
    @(posedge clk);
    #1;
    x1 = 1'b0; y1 = 1'b1;
    #1;
    total++;
    if (zq1 !== 1'b1) begin bad++; $display("FAIL b2b_zq got=%b want=1", zq1); end
    total++;
    if (z1 !== 1'b0) begin bad++; $display("FAIL b2b_z got=%b want=0", z1); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_random_edges();
    test_reset_hold();
    test_async_reset();
    test_wide();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mt2015_q4.md
# mt2015_q4

Combinational logic network built from two primitive cells, plus a registered copy of its result. Cell A computes (x XOR y) AND x; cell B computes XNOR(x, y). Two A instances and two B instances combine through OR, AND and XOR stages. The block is a small glue-logic leaf with a purely combinational output `z` and a one-cycle registered output `z_q` for synchronous consumers.

## Interface
- `WIDTH`, default 1: number of independent bit-lanes. Each lane is an identical network.
- `clk`  in  1  clock. Only `z_q` uses it.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `x`  in  WIDTH  first operand, one bit per lane.
- `y`  in  WIDTH  second operand, one bit per lane.
- `z`  out  WIDTH  combinational network result.
- `z_q`  out  WIDTH  `z` registered on the rising edge of `clk`.

One clock; reset is asynchronous and active-low.

## Operation
Each lane i is independent. Within a lane:
- Cell A: a = (x[i] ^ y[i]) & x[i], which equals x[i] & ~y[i].
- Cell B: b = ~(x[i] ^ y[i]).
- Stage 1: A1 and B1 are fed x[i], y[i]; o = a1 | b1.
- Stage 2: A2 and B2 are fed the same x[i], y[i]; n = a2 & b2.
- Output: z[i] = o ^ n.
- Net function: z[i] = x[i] | ~y[i]. Per (x, y): 00→1, 01→0, 10→1, 11→1.
- The network must be built from the A and B cells as listed, not collapsed by hand. Synthesis may simplify it.
- `z` has no X pessimism for known inputs. Every known input pair yields a known 0 or 1.
- `z_q[i]` captures `z[i]` on each rising `clk` edge. `rst_n` low forces `z_q` to 0.
- Reset does not affect `z`. `z` follows its inputs whether `rst_n` is high or low.

## Timing
- `z` has zero latency: pure combinational, no clock dependence.
- Inputs may change on either clock edge. `z` must settle within the same timestep, before any same-timestep sampler reads it.
- `z_q` has a latency of one rising edge.
- Reset value: `z_q` = 0. `z` has no reset value; it always reflects the current inputs.
- Reset assertion mid-operation clears `z_q` immediately (asynchronous).
- Reset release: `z_q` loads `z` on the first rising edge at which `rst_n` is high.
- Simultaneous input change and rising edge: `z_q` captures the pre-edge value of `z`, as with a normal nonblocking register.

## Structure
- Shared package `mt2015_q4_pkg` holds one constant: `MT2015_Q4_TRUTH` = 4'b1101. It is indexed by {x, y} and gives the expected z, for use by both the RTL assertions and the bench.
- One sub-module, `mt2015_q4_lane`. It is a 1-bit lane containing cells A and B as local functions or instances, wired into the OR/AND/XOR network.
- The top level generates WIDTH lanes and adds the `z_q` register bank with asynchronous clear.
- Add an assertion that `z` == (`x` | ~`y`) whenever the inputs are known.

## Test plan
- Exhaustive sweep at WIDTH=1 over x, y = 00, 01, 10, 11 → `z` = 1, 0, 1, 1 in the same timestep.
- Inputs changed on both rising and falling edges for 200 half-cycles with random x, y → zero mismatches against `x | ~y` at every edge.
- `rst_n` held low while inputs toggle → `z_q` stays 0 and `z` tracks its inputs. Release `rst_n` with x=0, y=1 → `z_q` = 0; then x=1, y=1 → `z_q` = 1 one edge later.
- `rst_n` asserted between edges while `z_q` = 1 → `z_q` drops to 0 immediately, without waiting for a clock edge.
- WIDTH=4, x=4'b0101, y=4'b0011 → `z` = 4'b1101; `z_q` = 4'b1101 after one rising edge.
- x=0, y=0 applied just before a rising edge, then x=0, y=1 right after it → `z_q` = 1 and `z` = 0.
